// File: rtl/crc_pkg.sv
// Shared FSM state type, standard CRC parameter sets and a bit-reversal helper
// for the CRC stream engine.
package crc_pkg;

   typedef enum logic [1:0] {IDLE, RUN, OUT} crc_state_e;

   localparam logic [32:0] CRC32_POLY         = 33'h104C11DB7;
   localparam logic [31:0] CRC32_INIT         = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_XOROUT       = 32'hFFFFFFFF;

   localparam logic [16:0] CRC16_CCITT_POLY   = 17'h11021;
   localparam logic [15:0] CRC16_CCITT_INIT   = 16'hFFFF;
   localparam logic [15:0] CRC16_CCITT_XOROUT = 16'h0000;

   localparam logic [16:0] CRC16_IBM_POLY     = 17'h18005;
   localparam logic [15:0] CRC16_IBM_INIT     = 16'h0000;
   localparam logic [15:0] CRC16_IBM_XOROUT   = 16'h0000;

   // Reverses the low i_width bits of i_val; bits above i_width come back as zero.
   function automatic logic [63:0] reverse_bits(input logic [63:0] i_val,
                                                input int unsigned i_width);
      logic [63:0] res;
      res = '0;
      for (int unsigned i = 0; i < 64; i++) begin
         if (i < i_width) res[i[5:0]] = i_val[6'(i_width - 1 - i)];
      end
      return res;
   endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Combinational CRC update: advances a CW-bit register by one byte, MSB first,
// using generator polynomial CP (CW+1 bits, top bit implicit).
module crc_byte_step
   import crc_pkg::*;
#(
   parameter int unsigned CW = 32,
   parameter logic [CW:0] CP = CRC32_POLY
) (
   input  logic [CW-1:0] i_crc,
   input  logic [7:0]    i_byte,
   output logic [CW-1:0] o_crc
);

   logic [CW-1:0] w_acc;

   always_comb begin
      w_acc = i_crc;
      for (int unsigned b = 0; b < 8; b++) begin
         if (w_acc[CW-1] ^ i_byte[3'(7 - b)]) w_acc = (w_acc << 1) ^ CP[CW-1:0];
         else                                w_acc = w_acc << 1;
      end
   end

   assign o_crc = w_acc;

endmodule

// File: rtl/crc_stream_engine.sv
// Frame-oriented streaming CRC generator: DW-bit beats, partial last beat,
// registered result. Define CRC_STREAM_CHECK_EN to add the Chk_o residue check.
module crc_stream_engine
   import crc_pkg::*;
#(
   parameter int unsigned   DW      = 64,
   parameter int unsigned   CW      = 32,
   parameter logic [CW:0]   CP      = 33'h104C11DB7,
   parameter logic [CW-1:0] INIT    = '1,
   parameter logic [CW-1:0] XOROUT  = '1,
   parameter bit            REFIN   = 1'b1,
   parameter bit            REFOUT  = 1'b1,
`ifdef CRC_STREAM_CHECK_EN
   parameter logic [CW-1:0] RESIDUE = CW'(32'hC704DD7B),
`endif
   parameter int unsigned   NBW     = (DW > 8) ? $clog2(DW / 8) : 1
) (
   input  logic           Clk_i,
   input  logic           Rst_i,
   input  logic [DW-1:0]  Dat_i,
   input  logic           Vld_i,
   output logic           Rdy_o,
   input  logic           Sof_i,
   input  logic           Eof_i,
   input  logic [NBW-1:0] Nb_i,
   output logic [CW-1:0]  Crc_o,
   output logic           CrcVld_o,
`ifdef CRC_STREAM_CHECK_EN
   output logic           Chk_o,
`endif
   input  logic           CrcRdy_i
);

   localparam int unsigned NB = DW / 8;

   crc_state_e     r_state;
   crc_state_e     w_state_nxt;
   logic [CW-1:0]  r_crc;
   logic [CW-1:0]  r_crc_out;
   logic           r_rdy;
   logic           w_xfer;
   logic [CW-1:0]  w_start;
   logic [CW-1:0]  w_next;
   logic [CW-1:0]  w_refl;
   logic [NBW-1:0] w_nb;
   logic [CW-1:0]  w_chain [0:NB];
   logic [7:0]     w_byte  [0:NB-1];
`ifdef CRC_STREAM_CHECK_EN
   logic           r_chk;
`endif

   assign w_xfer     = Vld_i & r_rdy;
   // IDLE always starts from INIT, so Sof only matters while a frame is running.
   assign w_start    = (r_state == RUN && !Sof_i) ? r_crc : INIT;
   assign w_chain[0] = w_start;
   assign w_nb       = (Nb_i > NBW'(NB - 1)) ? NBW'(NB - 1) : Nb_i;

   for (genvar g = 0; g < NB; g++) begin : g_step
      assign w_byte[g] = REFIN ? 8'(reverse_bits(64'(Dat_i[DW-1-8*g -: 8]), 8))
                               : Dat_i[DW-1-8*g -: 8];
      crc_byte_step #(
         .CW (CW),
         .CP (CP)
      ) u_step (
         .i_crc  (w_chain[g]),
         .i_byte (w_byte[g]),
         .o_crc  (w_chain[g+1])
      );
   end

   // On the Eof beat the result is tapped after byte Nb; later bytes are dropped.
   always_comb begin
      w_next = w_chain[NB];
      if (Eof_i) begin
         for (int unsigned j = 0; j < NB; j++) begin
            if (NBW'(j) == w_nb) w_next = w_chain[j+1];
         end
      end
   end

   assign w_refl = REFOUT ? CW'(reverse_bits(64'(w_next), CW)) : w_next;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE, RUN: if (w_xfer) w_state_nxt = Eof_i ? OUT : RUN;
         OUT:       if (CrcRdy_i) w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
         r_state   <= IDLE;
         r_crc     <= INIT;
         r_rdy     <= 1'b0;
         r_crc_out <= '0;
`ifdef CRC_STREAM_CHECK_EN
         r_chk     <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= (w_state_nxt != OUT);
         if (w_xfer) begin
            r_crc <= w_next;
            if (Eof_i) begin
               r_crc_out <= w_refl ^ XOROUT;
`ifdef CRC_STREAM_CHECK_EN
               r_chk     <= (w_next == RESIDUE);
`endif
            end
         end
      end
   end

   assign Rdy_o    = r_rdy;
   assign CrcVld_o = (r_state == OUT);
   assign Crc_o    = r_crc_out;
`ifdef CRC_STREAM_CHECK_EN
   assign Chk_o    = r_chk;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Self-checking bench for crc_stream_engine: CRC-32 and CRC-16/ARC on 8-bit beats,
// CRC-16/CCITT on 64-bit beats, against a byte-wise reference CRC model.
`timescale 1ns/1ps
module tb_crc_stream_engine;

   typedef logic [7:0] bq_t [$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  a_dat;
   logic        a_vld, a_sof, a_eof, a_nb, a_crcrdy;
   logic        a32_rdy, a32_vld, aarc_rdy, aarc_vld;
   logic [31:0] a32_crc;
   logic [15:0] aarc_crc;
   logic [63:0] b_dat;
   logic        b_vld, b_sof, b_eof, b_crcrdy, b_rdy, b_crcvld;
   logic [2:0]  b_nb;
   logic [15:0] b_crc;
`ifdef CRC_STREAM_CHECK_EN
   logic        a32_chk, aarc_chk, b_chk;
`endif

   int checks   = 0;
   int failures = 0;

   crc_stream_engine #(
      .DW(8), .CW(32), .CP(33'h104C11DB7), .INIT(32'hFFFFFFFF), .XOROUT(32'hFFFFFFFF),
      .REFIN(1'b1), .REFOUT(1'b1)
   ) u_crc32 (
      .Clk_i(clk), .Rst_i(rst), .Dat_i(a_dat), .Vld_i(a_vld), .Rdy_o(a32_rdy),
      .Sof_i(a_sof), .Eof_i(a_eof), .Nb_i(a_nb), .Crc_o(a32_crc), .CrcVld_o(a32_vld),
`ifdef CRC_STREAM_CHECK_EN
      .Chk_o(a32_chk),
`endif
      .CrcRdy_i(a_crcrdy)
   );

   crc_stream_engine #(
      .DW(8), .CW(16), .CP(17'h18005), .INIT(16'h0000), .XOROUT(16'h0000),
      .REFIN(1'b1), .REFOUT(1'b1)
   ) u_arc (
      .Clk_i(clk), .Rst_i(rst), .Dat_i(a_dat), .Vld_i(a_vld), .Rdy_o(aarc_rdy),
      .Sof_i(a_sof), .Eof_i(a_eof), .Nb_i(a_nb), .Crc_o(aarc_crc), .CrcVld_o(aarc_vld),
`ifdef CRC_STREAM_CHECK_EN
      .Chk_o(aarc_chk),
`endif
      .CrcRdy_i(a_crcrdy)
   );

   crc_stream_engine #(
      .DW(64), .CW(16), .CP(17'h11021), .INIT(16'hFFFF), .XOROUT(16'h0000),
`ifdef CRC_STREAM_CHECK_EN
      .RESIDUE(16'h0000),
`endif
      .REFIN(1'b0), .REFOUT(1'b0)
   ) u_ccitt (
      .Clk_i(clk), .Rst_i(rst), .Dat_i(b_dat), .Vld_i(b_vld), .Rdy_o(b_rdy),
      .Sof_i(b_sof), .Eof_i(b_eof), .Nb_i(b_nb), .Crc_o(b_crc), .CrcVld_o(b_crcvld),
`ifdef CRC_STREAM_CHECK_EN
      .Chk_o(b_chk),
`endif
      .CrcRdy_i(b_crcrdy)
   );

   // ---------------- reference model ----------------
   function automatic logic [63:0] tb_reflect(input logic [63:0] v, input int w);
      logic [63:0] r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

   // Reflected configs use the LSB-first table-free form with the mirrored polynomial.
   function automatic logic [63:0] ref_crc(input bq_t q, input int w, input logic [63:0] poly,
                                           input logic [63:0] init, input logic [63:0] xo,
                                           input bit refl);
      logic [63:0] mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      logic [63:0] crc;
      logic [63:0] rp;
      if (refl) begin
         rp  = tb_reflect(poly, w);
         crc = tb_reflect(init, w);
         foreach (q[i]) begin
            crc ^= {56'd0, q[i]};
            repeat (8) crc = crc[0] ? ((crc >> 1) ^ rp) : (crc >> 1);
         end
      end else begin
         crc = init;
         foreach (q[i]) begin
            crc ^= ({56'd0, q[i]} << (w - 8));
            repeat (8) crc = crc[w-1] ? (((crc << 1) ^ poly) & mask) : ((crc << 1) & mask);
         end
      end
      return (crc ^ xo) & mask;
   endfunction

   function automatic bq_t str_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic bq_t rand_bytes(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   // ---------------- stimulus ----------------
   task automatic a_beat(input logic [7:0] d, input logic s, input logic e, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         a_vld = 1'b0; a_dat = 8'($urandom); a_sof = 1'($urandom); a_eof = 1'($urandom);
         @(posedge clk); #1;
      end
      a_vld = 1'b1; a_dat = d; a_sof = s; a_eof = e; a_nb = 1'($urandom);
      t = 0;
      while (a32_rdy !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      checks++;
      if (a32_rdy !== 1'b1) begin
         $display("FAIL a_rdy_timeout got=%b exp=1", a32_rdy); failures++;
      end
      @(posedge clk); #1;
      a_vld = 1'b0;
   endtask

   task automatic a_frame(input bq_t q, input int maxgap);
      for (int i = 0; i < q.size(); i++)
         a_beat(q[i], i == 0, i == q.size() - 1, $urandom_range(maxgap, 0));
   endtask

   task automatic a_accept();
      a_crcrdy = 1'b1; @(posedge clk); #1; a_crcrdy = 1'b0;
   endtask

   task automatic b_beat(input logic [63:0] d, input logic s, input logic e,
                         input logic [2:0] nb, input int gap);
      int t;
      for (int g = 0; g < gap; g++) begin
         b_vld = 1'b0; b_dat = {$urandom, $urandom}; b_sof = 1'($urandom); b_eof = 1'($urandom);
         @(posedge clk); #1;
      end
      b_vld = 1'b1; b_dat = d; b_sof = s; b_eof = e; b_nb = nb;
      t = 0;
      while (b_rdy !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
      checks++;
      if (b_rdy !== 1'b1) begin
         $display("FAIL b_rdy_timeout got=%b exp=1", b_rdy); failures++;
      end
      @(posedge clk); #1;
      b_vld = 1'b0;
   endtask

   // Unused bytes of the last beat are filled with random junk.
   task automatic b_frame(input bq_t q, input bit first_sof, input int maxgap);
      int nbeats = (q.size() + 7) / 8;
      for (int bi = 0; bi < nbeats; bi++) begin
         logic [63:0] d;
         logic [2:0]  nb;
         bit          last = (bi == nbeats - 1);
         for (int k = 0; k < 8; k++) begin
            int idx = bi * 8 + k;
            d[63-8*k -: 8] = (idx < q.size()) ? q[idx] : 8'($urandom);
         end
         nb = last ? 3'((q.size() - 1) % 8) : 3'($urandom);
         b_beat(d, (bi == 0) && first_sof, last, nb, $urandom_range(maxgap, 0));
      end
   endtask

   task automatic b_accept();
      b_crcrdy = 1'b1; @(posedge clk); #1; b_crcrdy = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a32_rdy !== 1'b0) begin $display("FAIL rst_a32_rdy got=%b exp=0", a32_rdy); failures++; end
      checks++; if (a32_vld !== 1'b0) begin $display("FAIL rst_a32_vld got=%b exp=0", a32_vld); failures++; end
      checks++; if (a32_crc !== 32'h0) begin $display("FAIL rst_a32_crc got=%h exp=0", a32_crc); failures++; end
      checks++; if (aarc_crc !== 16'h0) begin $display("FAIL rst_arc_crc got=%h exp=0", aarc_crc); failures++; end
      checks++; if (b_rdy !== 1'b0) begin $display("FAIL rst_b_rdy got=%b exp=0", b_rdy); failures++; end
      checks++; if (b_crcvld !== 1'b0) begin $display("FAIL rst_b_vld got=%b exp=0", b_crcvld); failures++; end
      checks++; if (b_crc !== 16'h0) begin $display("FAIL rst_b_crc got=%h exp=0", b_crc); failures++; end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (a32_rdy !== 1'b1) begin $display("FAIL post_rst_a32_rdy got=%b exp=1", a32_rdy); failures++; end
      checks++; if (aarc_rdy !== 1'b1) begin $display("FAIL post_rst_arc_rdy got=%b exp=1", aarc_rdy); failures++; end
      checks++; if (b_rdy !== 1'b1) begin $display("FAIL post_rst_b_rdy got=%b exp=1", b_rdy); failures++; end
   endtask

   task automatic test_known_vectors();
      bq_t q = str_bytes("123456789");
      a_frame(q, 0);
      checks++; if (a32_vld !== 1'b1) begin $display("FAIL kv_a32_vld got=%b exp=1", a32_vld); failures++; end
      checks++; if (aarc_vld !== 1'b1) begin $display("FAIL kv_arc_vld got=%b exp=1", aarc_vld); failures++; end
      checks++; if (a32_crc !== 32'hCBF43926) begin $display("FAIL kv_crc32 got=%h exp=cbf43926", a32_crc); failures++; end
      checks++; if (aarc_crc !== 16'hBB3D) begin $display("FAIL kv_arc got=%h exp=bb3d", aarc_crc); failures++; end
      a_accept();
      checks++; if (a32_vld !== 1'b0) begin $display("FAIL kv_a32_vld_drop got=%b exp=0", a32_vld); failures++; end
      b_frame(q, 1'b1, 0);
      checks++; if (b_crcvld !== 1'b1) begin $display("FAIL kv_b_vld got=%b exp=1", b_crcvld); failures++; end
      checks++; if (b_crc !== 16'h29B1) begin $display("FAIL kv_ccitt got=%h exp=29b1", b_crc); failures++; end
      b_accept();
   endtask

   task automatic test_random_frames();
      for (int it = 0; it < 10; it++) begin
         bq_t q = rand_bytes($urandom_range(24, 1));
         logic [31:0] e32 = 32'(ref_crc(q, 32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1));
         logic [15:0] earc = 16'(ref_crc(q, 16, 64'h8005, 64'h0, 64'h0, 1'b1));
         logic [15:0] eb = 16'(ref_crc(q, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0));
         a_frame(q, 2);
         checks++; if (a32_crc !== e32) begin $display("FAIL rnd_crc32 len=%0d got=%h exp=%h", q.size(), a32_crc, e32); failures++; end
         checks++; if (aarc_crc !== earc) begin $display("FAIL rnd_arc len=%0d got=%h exp=%h", q.size(), aarc_crc, earc); failures++; end
         a_accept();
         b_frame(q, 1'b1, 2);
         checks++; if (b_crc !== eb) begin $display("FAIL rnd_ccitt len=%0d got=%h exp=%h", q.size(), b_crc, eb); failures++; end
         b_accept();
      end
   endtask

   task automatic test_back_to_back();
      bq_t q1 = rand_bytes(13);
      bq_t q2 = rand_bytes(6);
      logic [15:0] e1 = 16'(ref_crc(q1, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0));
      logic [15:0] e2 = 16'(ref_crc(q2, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0));
      b_frame(q1, 1'b1, 0);
      for (int c = 0; c < 5; c++) begin
         checks++; if (b_crc !== e1) begin $display("FAIL hold_crc cyc=%0d got=%h exp=%h", c, b_crc, e1); failures++; end
         checks++; if (b_crcvld !== 1'b1) begin $display("FAIL hold_vld cyc=%0d got=%b exp=1", c, b_crcvld); failures++; end
         checks++; if (b_rdy !== 1'b0) begin $display("FAIL hold_rdy cyc=%0d got=%b exp=0", c, b_rdy); failures++; end
         @(posedge clk); #1;
      end
      b_accept();
      checks++; if (b_crcvld !== 1'b0) begin $display("FAIL b2b_vld_drop got=%b exp=0", b_crcvld); failures++; end
      checks++; if (b_rdy !== 1'b1) begin $display("FAIL b2b_idle_rdy got=%b exp=1", b_rdy); failures++; end
      b_frame(q2, 1'b1, 0);
      checks++; if (b_crc !== e2) begin $display("FAIL b2b_crc got=%h exp=%h", b_crc, e2); failures++; end
      b_accept();
   endtask

   task automatic test_sof_abort();
      bq_t q = str_bytes("123456789");
      b_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'($urandom), 0);
      b_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'($urandom), 1);
      b_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'($urandom), 0);
      b_frame(q, 1'b1, 1);
      checks++; if (b_crc !== 16'h29B1) begin $display("FAIL abort_ccitt got=%h exp=29b1", b_crc); failures++; end
      b_accept();
      a_beat(8'($urandom), 1'b1, 1'b0, 0);
      a_beat(8'($urandom), 1'b0, 1'b0, 0);
      a_beat(8'($urandom), 1'b0, 1'b0, 0);
      a_frame(q, 1);
      checks++; if (a32_crc !== 32'hCBF43926) begin $display("FAIL abort_crc32 got=%h exp=cbf43926", a32_crc); failures++; end
      a_accept();
   endtask

   task automatic test_reset_midframe();
      bq_t q = rand_bytes(11);
      logic [15:0] e = 16'(ref_crc(q, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0));
      b_beat({$urandom, $urandom}, 1'b1, 1'b0, 3'($urandom), 0);
      b_beat({$urandom, $urandom}, 1'b0, 1'b0, 3'($urandom), 0);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++; if (b_crcvld !== 1'b0) begin $display("FAIL midrst_vld cyc=%0d got=%b exp=0", c, b_crcvld); failures++; end
         @(posedge clk); #1;
      end
      b_frame(q, 1'b1, 1);
      checks++; if (b_crc !== e) begin $display("FAIL midrst_crc got=%h exp=%h", b_crc, e); failures++; end
      b_accept();
   endtask

   task automatic test_implied_sof();
      bq_t q = rand_bytes(17);
      logic [15:0] e = 16'(ref_crc(q, 16, 64'h1021, 64'hFFFF, 64'h0, 1'b0));
      b_frame(q, 1'b0, 1);
      checks++; if (b_crc !== e) begin $display("FAIL nosof_crc got=%h exp=%h", b_crc, e); failures++; end
      b_accept();
   endtask

`ifdef CRC_STREAM_CHECK_EN
   task automatic test_residue();
      bq_t q = str_bytes("123456789");
      q.push_back(8'h29);
      q.push_back(8'hB1);
      b_frame(q, 1'b1, 0);
      checks++; if (b_chk !== 1'b1) begin $display("FAIL chk_good got=%b exp=1", b_chk); failures++; end
      b_accept();
      q[3] = q[3] ^ 8'h10;
      b_frame(q, 1'b1, 0);
      checks++; if (b_chk !== 1'b0) begin $display("FAIL chk_bad got=%b exp=0", b_chk); failures++; end
      b_accept();
   endtask
`endif

   initial begin
      rst = 1'b1;
      a_dat = '0; a_vld = 1'b0; a_sof = 1'b0; a_eof = 1'b0; a_nb = 1'b0; a_crcrdy = 1'b0;
      b_dat = '0; b_vld = 1'b0; b_sof = 1'b0; b_eof = 1'b0; b_nb = '0; b_crcrdy = 1'b0;
      test_reset();
      test_known_vectors();
      test_random_frames();
      test_back_to_back();
      test_sof_abort();
      test_reset_midframe();
      test_implied_sof();
`ifdef CRC_STREAM_CHECK_EN
      test_residue();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
Pipelined, frame-oriented CRC generator for streaming data. It accepts DW-bit beats under a valid/ready handshake, carries the CRC register across beats, and supports a partial last beat. Init, reflection and final XOR are all parametrised. It sits between a packet source and the framer/checker, and is the clocked, multi-beat generalisation of the team's combinational CRC kernel.

Parameters:
- DW, 64, data beat width in bits; must be a multiple of 8 and ≥8.
- CW, 32, CRC width.
- CP, 33'h104C11DB7, generator polynomial, CW+1 bits including the implicit top bit.
- INIT, {CW{1'b1}}, register value loaded at the start of each frame.
- XOROUT, {CW{1'b1}}, XOR applied to the result.
- REFIN, 1, bit-reverse each input byte before processing.
- REFOUT, 1, bit-reverse the CW-bit result before XOROUT.
- NBW, $clog2(DW/8) (min 1), width of Nb_i.

Ports:
- Clk_i  in  1  clock.
- Rst_i  in  1  synchronous active-high reset.
- Dat_i  in  DW  data beat; byte 0 = Dat_i[DW-1:DW-8] is processed first.
- Vld_i  in  1  beat valid.
- Rdy_o  out  1  beat ready; a beat transfers when Vld_i&Rdy_o.
- Sof_i  in  1  first beat of frame (qualified by transfer).
- Eof_i  in  1  last beat of frame (qualified by transfer).
- Nb_i  in  NBW  valid bytes minus 1 on the Eof beat; ignored otherwise.
- Crc_o  out  CW  final CRC; stable while CrcVld_o=1.
- CrcVld_o  out  1  result valid.
- CrcRdy_i  in  1  result accepted when CrcVld_o&CrcRdy_i.

Behaviour:
- Single clock Clk_i; Rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE, CRC register=INIT.
  - Rdy_o=0 in the reset cycle and 1 from the cycle after.
  - CrcVld_o=0, Crc_o=0.
- FSM:
  - IDLE: Rdy_o=1. Any transfer loads the register from INIT and processes the beat, whether Sof_i is high or not (Sof is implied). Transfer with Eof → OUT, otherwise → RUN.
  - RUN: Rdy_o=1. A transfer with Sof_i=1 discards the partial CRC and restarts from INIT. A transfer with Eof → OUT.
  - OUT: Rdy_o=0 and CrcVld_o=1. On CrcRdy_i → IDLE, with CrcVld_o low next cycle. This gives one bubble between frames.
- Per-beat update:
  - Bytes 0..k are processed MSB-first with the polynomial CP. k=DW/8-1, except on the Eof beat where k=Nb_i.
  - Nb_i values above DW/8-1 are clamped to DW/8-1.
  - Bytes past k do not affect the result.
- Output:
  - Crc_o = (REFOUT ? reverse(reg) : reg) ^ XOROUT.
  - Crc_o is registered and valid the cycle after the Eof transfer, so latency is 1 cycle.
- Sof_i=Eof_i=1 on the same beat is a single-beat frame.
- Vld_i=0 beats leave the register unchanged, including while in RUN.
- Dat_i, Sof_i, Eof_i and Nb_i are don't-care when no transfer occurs.
- Rst_i asserted in any state returns to IDLE next cycle and drops CrcVld_o. A partial frame is lost.
- Arithmetic is pure GF(2) with no carries; the register is exactly CW bits.

Optional Feature:
- Macro: CRC_STREAM_CHECK_EN.
- When defined:
  - Adds output port Chk_o (1 bit) and parameter RESIDUE (CW bits, default 32'hC704DD7B).
  - Chk_o is registered alongside CrcVld_o: 1 when the raw register after the Eof beat equals RESIDUE. "Raw" means unreflected, before REFOUT/XOROUT.
  - This lets frames with the CRC appended be checked.
- When undefined: no Chk_o port and no comparator logic.

Decomposition:
- Package crc_pkg holds:
  - FSM state typedef {IDLE, RUN, OUT}.
  - Standard polynomial/INIT/XOROUT constants: CRC32, CRC16_CCITT, CRC16_IBM.
  - A reverse-bits function.
- One sub-module, crc_byte_step: combinational update of CW-bit state by one 8-bit byte with polynomial CP. It is instantiated DW/8 times as a chain. The Eof-beat result is selected by Nb_i from the chain taps.

Test Plan:
- CRC-32 defaults, DW=8, ASCII "123456789" as 9 beats (Sof on first, Eof on last) → Crc_o=32'hCBF43926, one cycle after the Eof transfer.
- DW=64, CW=16, CP=17'h11021, INIT=16'hFFFF, XOROUT=0, REFIN=REFOUT=0. Input "12345678" then "9" with Nb_i=0 → Crc_o=16'h29B1; junk in the unused bytes of the last beat gives the same result.
- CRC-16/ARC (CP=17'h18005, INIT=0, XOROUT=0, REFIN=REFOUT=1), DW=8, "123456789" → 16'hBB3D.
- CrcRdy_i held low for 5 cycles → Crc_o stable, CrcVld_o=1, Rdy_o=0 throughout. On CrcRdy_i=1, IDLE follows next cycle, and a back-to-back frame gives the correct CRC.
- Abort and idle cases:
  - Sof mid-frame after 3 beats, then "123456789" → CRC of the new frame only (16'h29B1 in the CCITT configuration).
  - Rst_i mid-frame → CrcVld_o stays 0 and the next frame is correct.
  - Vld_i gaps between beats → result unchanged.
- CRC_STREAM_CHECK_EN with the CCITT configuration and RESIDUE=0: "123456789",8'h29,8'hB1 → Chk_o=1. Flipping one data bit → Chk_o=0.
